// File: rtl/mlp_pkg.sv
// Shared widths, config addresses and scheduler state encoding for the mlp batch scheduler.
package mlp_pkg;

  localparam int SAMPLE_W = 56;
  localparam int RES_W    = 8;
  localparam int W1_W     = 64;
  localparam int W2_W     = 24;

  localparam logic [1:0] CFG_ADDR_W11 = 2'd0;
  localparam logic [1:0] CFG_ADDR_W12 = 2'd1;
  localparam logic [1:0] CFG_ADDR_W21 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_RUN     = 3'd2,
    ST_RELEASE = 3'd3,
    ST_EMIT    = 3'd4,
    ST_FINISH  = 3'd5
  } sched_state_t;

endpackage

// File: rtl/mlp_batch_sched_if.sv
// Sample-in / result-out valid-ready streams of the batch scheduler.
// slave = scheduler side, master = producer/consumer side.
interface mlp_batch_sched_if;

  logic                         s_valid;
  logic                         s_ready;
  logic [mlp_pkg::SAMPLE_W-1:0] s_data;
  logic                         m_valid;
  logic                         m_ready;
  logic [mlp_pkg::RES_W-1:0]    m_data;
  logic                         m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/mlp_weight_regs.sv
// Weight register file for the mlp core; writes land only while wr_en allows them.
module mlp_weight_regs
  import mlp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic            wr_en,
  input  logic [1:0]      addr,
  input  logic [W1_W-1:0] wdata,
  output logic [W1_W-1:0] w11,
  output logic [W1_W-1:0] w12,
  output logic [W2_W-1:0] w21
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w11 <= '0;
      w12 <= '0;
      w21 <= '0;
    end else if (we && wr_en) begin
      case (addr)
        CFG_ADDR_W11: w11 <= wdata;
        CFG_ADDR_W12: w12 <= wdata;
        CFG_ADDR_W21: w21 <= wdata[W2_W-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mlp_batch_sched.sv
// Batch scheduler in front of the mlp core: four-phase start/done per sample, result stream out.
// Optional core_done timeout with sticky err_timeout when MLP_SCHED_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for batch_start; weights writable
// FETCH   | s_ready high, waiting for next sample
// RUN     | core_start high until core_done seen
// RELEASE | core_start low, waiting for core_done to fall
// EMIT    | result offered on m stream
// FINISH  | one-cycle batch_done, back to IDLE
module mlp_batch_sched
  import mlp_pkg::*;
#(
  parameter int BATCH       = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_addr,
  input  logic [W1_W-1:0]          cfg_wdata,
  input  logic                     batch_start,
  input  logic [$clog2(BATCH):0]   batch_len,
  output logic                     busy,
  output logic                     batch_done,
  mlp_batch_sched_if.slave         strm,
  output logic                     core_start,
  output logic [SAMPLE_W-1:0]      core_data_in,
  output logic [W1_W-1:0]          core_w11,
  output logic [W1_W-1:0]          core_w12,
  output logic [W2_W-1:0]          core_w21,
  input  logic                     core_done,
  input  logic [RES_W-1:0]         core_data_out
`ifdef MLP_SCHED_TIMEOUT_EN
  ,
  output logic                     err_timeout
`endif
);

  localparam int LEN_W = $clog2(BATCH) + 1;

  sched_state_t     state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_clamped;
  logic             cfg_gate;

  assign len_clamped = (batch_len > LEN_W'(BATCH)) ? LEN_W'(BATCH) : batch_len;
  // The IDLE cycle that still shows busy (batch tail) is treated as busy for writes too.
  assign cfg_gate    = (state == ST_IDLE) && !busy && !batch_start;

  mlp_weight_regs u_weight_regs (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .wr_en (cfg_gate),
    .addr  (cfg_addr),
    .wdata (cfg_wdata),
    .w11   (core_w11),
    .w12   (core_w12),
    .w21   (core_w21)
  );

`ifdef MLP_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             in_core_wait;
  assign in_core_wait = (state == ST_RUN) || (state == ST_RELEASE);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      len          <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      batch_done   <= 1'b0;
      strm.s_ready <= 1'b0;
      strm.m_valid <= 1'b0;
      strm.m_data  <= '0;
      strm.m_last  <= 1'b0;
      core_start   <= 1'b0;
      core_data_in <= '0;
`ifdef MLP_SCHED_TIMEOUT_EN
      tmo_cnt      <= '0;
      err_timeout  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          batch_done <= 1'b0;
          if (busy) begin
            busy <= 1'b0;
          end else if (batch_start) begin
            busy <= 1'b1;
            len  <= len_clamped;
            cnt  <= '0;
`ifdef MLP_SCHED_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            if (len_clamped == '0) begin
              state <= ST_FINISH;
            end else begin
              state        <= ST_FETCH;
              strm.s_ready <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (strm.s_valid) begin
            core_data_in <= strm.s_data;
            strm.s_ready <= 1'b0;
            core_start   <= 1'b1;
            state        <= ST_RUN;
`ifdef MLP_SCHED_TIMEOUT_EN
            tmo_cnt      <= TMO_W'(TIMEOUT_CYC - 1);
`endif
          end
        end
        ST_RUN: begin
          if (core_done) begin
            core_start  <= 1'b0;
            strm.m_data <= core_data_out;
            state       <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!core_done) begin
            strm.m_valid <= 1'b1;
            strm.m_last  <= (cnt == (len - LEN_W'(1)));
            state        <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (strm.m_ready) begin
            strm.m_valid <= 1'b0;
            strm.m_last  <= 1'b0;
            cnt          <= cnt + LEN_W'(1);
            if ((cnt + LEN_W'(1)) == len) begin
              state <= ST_FINISH;
            end else begin
              state        <= ST_FETCH;
              strm.s_ready <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          batch_done <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
`ifdef MLP_SCHED_TIMEOUT_EN
      // Down-counter loaded at sample accept; terminal count aborts the rest of the batch.
      if (in_core_wait) begin
        if (tmo_cnt == '0) begin
          err_timeout  <= 1'b1;
          core_start   <= 1'b0;
          strm.m_valid <= 1'b0;
          strm.m_last  <= 1'b0;
          state        <= ST_FINISH;
        end else begin
          tmo_cnt <= tmo_cnt - TMO_W'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_mlp_batch_sched.sv
// Self-checking bench for mlp_batch_sched: table-driven batches, random stalls, corner sequences.
`timescale 1ns/1ps
module tb_mlp_batch_sched;
  import mlp_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_addr = '0;
  logic [W1_W-1:0]   cfg_wdata = '0;
  logic              batch_start = 1'b0;
  logic [6:0]        batch_len = '0;
  logic              busy, batch_done, core_start;
  logic [SAMPLE_W-1:0] core_data_in;
  logic [W1_W-1:0]   core_w11, core_w12;
  logic [W2_W-1:0]   core_w21;
  logic              core_done;
  logic [RES_W-1:0]  core_data_out;
  logic              core_hang = 1'b0;
  logic [1:0]        core_cnt;
`ifdef MLP_SCHED_TIMEOUT_EN
  logic              err_timeout;
`endif

  int checks = 0;
  int failures = 0;
  int start_viol = 0, mv_viol = 0, sr_viol = 0;

  mlp_batch_sched_if strm ();

  always #5 clk = ~clk;

  mlp_batch_sched #(.BATCH(64), .TIMEOUT_CYC(255)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .batch_start   (batch_start),
    .batch_len     (batch_len),
    .busy          (busy),
    .batch_done    (batch_done),
    .strm          (strm),
    .core_start    (core_start),
    .core_data_in  (core_data_in),
    .core_w11      (core_w11),
    .core_w12      (core_w12),
    .core_w21      (core_w21),
    .core_done     (core_done),
    .core_data_out (core_data_out)
`ifdef MLP_SCHED_TIMEOUT_EN
    ,
    .err_timeout   (err_timeout)
`endif
  );

  function automatic logic [7:0] core_fn(input logic [55:0] d);
    logic [7:0] s;
    s = 8'h5A;
    for (int k = 0; k < 7; k++) s = {s[6:0], s[7]} ^ d[8*k +: 8];
    return s;
  endfunction

  // Behavioural mlp core: done 3 cycles after start, held until start drops.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_done     <= 1'b0;
      core_cnt      <= '0;
      core_data_out <= '0;
    end else if (!core_hang) begin
      if (core_start && !core_done) begin
        if (core_cnt == 2'd2) begin
          core_done     <= 1'b1;
          core_data_out <= core_fn(core_data_in);
          core_cnt      <= '0;
        end else begin
          core_cnt <= core_cnt + 2'd1;
        end
      end else if (!core_start) begin
        core_done <= 1'b0;
        core_cnt  <= '0;
      end
    end
  end

  logic       p_done = 1'b0, p_mv = 1'b0, p_mr = 1'b0;
  logic [7:0] p_md = '0;
  always @(posedge clk) begin
    if (rst) begin
      if (p_done && core_start) start_viol++;
      if (p_mv && !p_mr && (!strm.m_valid || strm.m_data !== p_md)) mv_viol++;
      if (strm.s_ready && strm.m_valid) sr_viol++;
    end
    p_done = core_done;
    p_mv   = strm.m_valid;
    p_mr   = strm.m_ready;
    p_md   = strm.m_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [63:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_batch(input int len_in, input int exp_n, input int s_stall,
                           input int m_stall, input int hold, input bit poke);
    logic [55:0] smp[$];
    logic [7:0]  expq[$];
    logic [63:0] rnd;
    logic [7:0]  hold_data;
    int n, idx, ridx, holdc;
    bit done_seen, acc_pend, fall_pend, prev_dn, extra_sr, hold_bad;
    n = (len_in > 64) ? 64 : len_in;
    idx = 0; ridx = 0; holdc = 0; hold_data = '0;
    done_seen = 0; acc_pend = 0; fall_pend = 0; prev_dn = 0; extra_sr = 0; hold_bad = 0;
    for (int i = 0; i < n; i++) begin
      rnd = {$urandom, $urandom};
      smp.push_back(rnd[55:0]);
      expq.push_back(core_fn(rnd[55:0]));
    end
    @(negedge clk);
    batch_start = 1'b1;
    batch_len   = 7'(len_in);
    if (poke) begin
      cfg_we = 1'b1; cfg_addr = 2'($urandom_range(2)); cfg_wdata = '1;
    end
    @(negedge clk);
    batch_start = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (acc_pend) check("core_start_latency", core_start, 1);
      if (fall_pend) check("result_latency", strm.m_valid, 1);
      acc_pend  = 0;
      fall_pend = prev_dn && !core_done;
      prev_dn   = core_done;
      if (batch_done) begin
        done_seen = 1;
        break;
      end
      if (strm.s_ready && idx >= n) extra_sr = 1;
      rnd = {$urandom, $urandom};
      strm.s_valid = (idx < n) && ($urandom_range(99) >= s_stall);
      if (strm.s_valid) strm.s_data = smp[idx];
      else strm.s_data = rnd[55:0];
      if (strm.s_valid && strm.s_ready) begin
        idx++;
        acc_pend = 1;
      end
      if (strm.m_valid && holdc < hold) begin
        if (holdc == 0) hold_data = strm.m_data;
        else if (strm.m_data !== hold_data) hold_bad = 1;
        strm.m_ready = 1'b0;
        holdc++;
      end else begin
        if (holdc > 0 && holdc < hold) hold_bad = 1;
        strm.m_ready = ($urandom_range(99) >= m_stall);
      end
      if (strm.m_valid && strm.m_ready) begin
        if (ridx < n) begin
          check("m_data", strm.m_data, expq[ridx]);
          check("m_last", strm.m_last, (ridx == n - 1));
        end
        ridx++;
      end
      @(negedge clk);
    end
    strm.s_valid = 1'b0; strm.m_ready = 1'b0; cfg_we = 1'b0;
    check("batch_done_seen", done_seen, 1);
    check("result_count", ridx, exp_n);
    check("samples_taken", idx, exp_n);
    check("busy_at_done", busy, 1);
    check("extra_s_ready", extra_sr, 0);
    if (hold > 0) check("hold_stable", hold_bad, 0);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("batch_done_width", batch_done, 0);
  endtask

  typedef struct {
    int len;
    int exp_n;
    int s_stall;
    int m_stall;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [63:0] r;
    bit bad;
    bit seen;
    vecs[0] = '{4, 4, 0, 0};
    vecs[1] = '{1, 1, 30, 30};
    vecs[2] = '{7, 7, 50, 20};
    vecs[3] = '{100, 64, 10, 10};
    vecs[4] = '{64, 64, 0, 40};
    vecs[5] = '{3, 3, 70, 70};
    strm.s_valid = 1'b0; strm.s_data = '0; strm.m_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_batch_done", batch_done, 0);
    check("rst_s_ready", strm.s_ready, 0);
    check("rst_m_valid", strm.m_valid, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_w11", core_w11, 0);
    check("rst_core_data_in", core_data_in, 0);
    rst = 1'b1;

    cfg_write(2'd0, 64'h0102030405060708);
    cfg_write(2'd1, 64'h1122334455667788);
    cfg_write(2'd2, 64'hFFFF_FFFF_FF0A_0B0C);
    cfg_write(2'd3, 64'hDEAD_BEEF_DEAD_BEEF);
    check("core_w11", core_w11, 64'h0102030405060708);
    check("core_w12", core_w12, 64'h1122334455667788);
    check("core_w21", core_w21, 24'h0A0B0C);

    for (int v = 0; v < 6; v++)
      run_batch(vecs[v].len, vecs[v].exp_n, vecs[v].s_stall, vecs[v].m_stall, 0, 0);
    for (int v = 0; v < 4; v++) begin
      int l;
      l = $urandom_range(1, 70);
      run_batch(l, (l > 64) ? 64 : l, $urandom_range(60), $urandom_range(60), 0, 0);
    end

    run_batch(2, 2, 0, 0, 10, 0);

    run_batch(5, 5, 20, 20, 0, 1);
    check("poke_w11", core_w11, 64'h0102030405060708);
    check("poke_w12", core_w12, 64'h1122334455667788);
    check("poke_w21", core_w21, 24'h0A0B0C);

    bad = 0;
    @(negedge clk); batch_start = 1'b1; batch_len = 7'd0;
    @(negedge clk); batch_start = 1'b0;
    check("len0_busy_k1", busy, 1);
    check("len0_done_k1", batch_done, 0);
    if (strm.s_ready || core_start) bad = 1;
    @(negedge clk);
    check("len0_done_k2", batch_done, 1);
    if (strm.s_ready || core_start) bad = 1;
    @(negedge clk);
    check("len0_done_k3", batch_done, 0);
    check("len0_busy_k3", busy, 0);
    if (strm.s_ready || core_start) bad = 1;
    check("len0_no_activity", bad, 0);

    @(negedge clk); batch_start = 1'b1; batch_len = 7'd3;
    @(negedge clk); batch_start = 1'b0;
    r = {$urandom, $urandom};
    strm.s_data = r[55:0]; strm.s_valid = 1'b1;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      if (core_start) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("midrun_core_start_seen", seen, 1);
    strm.s_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrun_core_start", core_start, 0);
    check("midrun_busy", busy, 0);
    check("midrun_s_ready", strm.s_ready, 0);
    check("midrun_m_valid", strm.m_valid, 0);
    check("midrun_core_data_in", core_data_in, 0);
    check("midrun_w11", core_w11, 0);
    check("midrun_w21", core_w21, 0);
    @(negedge clk); rst = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (batch_done || busy) bad = 1;
    end
    check("midrun_no_batch_done", bad, 0);
    cfg_write(2'd0, 64'h0102030405060708);
    cfg_write(2'd2, 64'h0000_0000_000A_0B0C);
    check("post_rst_w11", core_w11, 64'h0102030405060708);
    check("post_rst_w12", core_w12, 0);
    run_batch(3, 3, 10, 10, 0, 0);

`ifdef MLP_SCHED_TIMEOUT_EN
    begin : tmo_blk
      int hi_cnt;
      bit dn, mv_seen;
      hi_cnt = 0; dn = 0; mv_seen = 0;
      core_hang = 1'b1;
      @(negedge clk); batch_start = 1'b1; batch_len = 7'd3;
      @(negedge clk); batch_start = 1'b0;
      r = {$urandom, $urandom};
      strm.s_data = r[55:0]; strm.s_valid = 1'b1; strm.m_ready = 1'b1;
      for (int c = 0; c < 1000; c++) begin
        if (core_start) begin
          hi_cnt++;
          strm.s_valid = 1'b0;
        end
        if (strm.m_valid) mv_seen = 1;
        if (batch_done) begin
          dn = 1;
          break;
        end
        @(negedge clk);
      end
      strm.s_valid = 1'b0; strm.m_ready = 1'b0;
      check("tmo_batch_done", dn, 1);
      check("tmo_start_cycles", hi_cnt, 255);
      check("tmo_err_set", err_timeout, 1);
      check("tmo_no_result", mv_seen, 0);
      check("tmo_core_start_low", core_start, 0);
      @(negedge clk);
      check("tmo_busy_after", busy, 0);
      core_hang = 1'b0;
      repeat (3) @(negedge clk);
      check("tmo_err_sticky", err_timeout, 1);
      run_batch(2, 2, 0, 0, 0, 0);
      check("tmo_err_cleared", err_timeout, 0);
    end
`endif

    check("core_start_vs_done", start_viol, 0);
    check("m_valid_stability", mv_viol, 0);
    check("s_ready_while_m_valid", sr_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
